ring_fifo: RTL and testbench

RING_FIFO -- requirements
Module: ring_fifo

---
 rtl/ring_fifo_pkg.sv | 24 ++
 rtl/ring_fifo_mem.sv | 49 ++++
 rtl/ring_fifo.sv | 144 ++++++++++++++
 tb/tb_ring_fifo.sv | 224 ++++++++++++++++++++++
 4 files changed

// File: rtl/ring_fifo_pkg.sv
// ring_fifo_pkg: shared width helpers and constants for the ring_fifo block.
//   ptr_width   - bits in a read/write pointer for a given log2 depth
//   count_width - bits needed to hold an occupancy of 0..Depth
//   depth_of    - number of entries for a given log2 depth
//   StatsWidth  - width of the optional drop/miss statistics counters
//                 (present only when RING_FIFO_STATS_EN is defined)
package ring_fifo_pkg;

    localparam int unsigned StatsWidth = 16;

    function automatic int unsigned ptr_width(input int unsigned length_bits);
        return length_bits;
    endfunction

    // One extra bit so that a completely full FIFO (count == Depth) is representable.
    function automatic int unsigned count_width(input int unsigned length_bits);
        return length_bits + 1;
    endfunction

    function automatic int unsigned depth_of(input int unsigned length_bits);
        return 32'd1 << length_bits;
    endfunction

endpackage : ring_fifo_pkg

// File: rtl/ring_fifo_mem.sv
// ring_fifo_mem: simple dual-port storage for ring_fifo.
//   One synchronous write port and one registered read port on the same clock.
//   The storage array is never reset; only the read data register is.
//   Ports:
//     clk        in  clock, rising edge
//     reset      in  synchronous active-high reset (read register only)
//     i_wr_en    in  write strobe
//     i_wr_addr  in  write address
//     i_wr_data  in  write data
//     i_rd_en    in  read strobe; o_rd_data updates on the next edge
//     i_rd_addr  in  read address
//     o_rd_data  out registered read data, held while i_rd_en is low
module ring_fifo_mem
    import ring_fifo_pkg::*;
#(
    parameter int unsigned WordSize = 8,
    parameter int unsigned AddrBits = 3
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                i_wr_en,
    input  logic [AddrBits-1:0] i_wr_addr,
    input  logic [WordSize-1:0] i_wr_data,
    input  logic                i_rd_en,
    input  logic [AddrBits-1:0] i_rd_addr,
    output logic [WordSize-1:0] o_rd_data
);

    localparam int unsigned Depth = depth_of(AddrBits);

    logic [WordSize-1:0] r_mem [Depth];

    // Write port: no reset so the array maps onto plain RAM.
    always_ff @(posedge clk) begin
        if (i_wr_en) begin
            r_mem[i_wr_addr] <= i_wr_data;
        end
    end

    // Read port: read-before-write, so a same-address write lands after the read.
    always_ff @(posedge clk) begin
        if (reset) begin
            o_rd_data <= '0;
        end else if (i_rd_en) begin
            o_rd_data <= r_mem[i_rd_addr];
        end
    end

endmodule : ring_fifo_mem

// File: rtl/ring_fifo.sv
// ring_fifo: single-clock circular FIFO with registered read data and status.
//   State is write pointer, read pointer (natural wrap) and an occupancy count.
//   A read returns data one cycle after it is accepted, flagged by dataReadAck.
//   When full, a simultaneous read frees the slot the write then fills.
//   When empty, a simultaneous write is accepted but the read is rejected.
//   Optional macro RING_FIFO_STATS_EN adds saturating dropCount / missCount.
//   Ports:
//     clk, reset                    clock and synchronous active-high reset
//     dataWriteEnable, dataWrite    write request and data
//     dataReadEnable                read request
//     dataReadAck, dataRead         registered read valid and data
//     count                         occupancy 0..Depth
//     empty, full, almostFull       registered status flags
//     overflow, underflow           sticky error flags
//     dropCount, missCount          (RING_FIFO_STATS_EN only) event counters
module ring_fifo
    import ring_fifo_pkg::*;
#(
    parameter int unsigned WordSize        = 8,
    parameter int unsigned LengthBits      = 3,
    parameter int unsigned AlmostFullLevel = (2 ** LengthBits) - 1
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  dataWriteEnable,
    input  logic [WordSize-1:0]   dataWrite,
    input  logic                  dataReadEnable,
    output logic                  dataReadAck,
    output logic [WordSize-1:0]   dataRead,
    output logic [LengthBits:0]   count,
    output logic                  empty,
    output logic                  full,
    output logic                  almostFull,
    output logic                  overflow,
    output logic                  underflow
`ifdef RING_FIFO_STATS_EN
    ,
    output logic [StatsWidth-1:0] dropCount,
    output logic [StatsWidth-1:0] missCount
`endif
);

    localparam int unsigned PtrW  = ptr_width(LengthBits);
    localparam int unsigned CntW  = count_width(LengthBits);
    localparam int unsigned Depth = depth_of(LengthBits);

    logic [PtrW-1:0] r_wr_ptr;
    logic [PtrW-1:0] r_rd_ptr;
    logic [CntW-1:0] r_count;

    logic            w_rd_accept;
    logic            w_wr_accept;
    logic            w_drop;
    logic            w_miss;
    logic [CntW-1:0] w_count_next;

    // Accept decisions: a read needs data present; a write needs room, or a
    // concurrent accepted read freeing a slot.
    always_comb begin
        w_rd_accept  = 1'b0;
        w_wr_accept  = 1'b0;
        w_drop       = 1'b0;
        w_miss       = 1'b0;
        w_count_next = r_count;

        w_rd_accept = dataReadEnable && (r_count != '0);
        w_wr_accept = dataWriteEnable && ((r_count != CntW'(Depth)) || w_rd_accept);
        w_drop      = dataWriteEnable && !w_wr_accept;
        w_miss      = dataReadEnable && !w_rd_accept;

        case ({w_wr_accept, w_rd_accept})
            2'b10:   w_count_next = r_count + CntW'(1);
            2'b01:   w_count_next = r_count - CntW'(1);
            default: w_count_next = r_count;
        endcase
    end

    // Pointers, occupancy and registered status.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_wr_ptr    <= '0;
            r_rd_ptr    <= '0;
            r_count     <= '0;
            dataReadAck <= 1'b0;
            empty       <= 1'b1;
            full        <= 1'b0;
            almostFull  <= 1'b0;
            overflow    <= 1'b0;
            underflow   <= 1'b0;
        end else begin
            if (w_wr_accept) begin
                r_wr_ptr <= r_wr_ptr + PtrW'(1);
            end
            if (w_rd_accept) begin
                r_rd_ptr <= r_rd_ptr + PtrW'(1);
            end
            r_count     <= w_count_next;
            dataReadAck <= w_rd_accept;
            empty       <= (w_count_next == '0);
            full        <= (w_count_next == CntW'(Depth));
            almostFull  <= (w_count_next >= CntW'(AlmostFullLevel));
            if (w_drop) begin
                overflow <= 1'b1;
            end
            if (w_miss) begin
                underflow <= 1'b1;
            end
        end
    end

    assign count = r_count;

`ifdef RING_FIFO_STATS_EN
    // Saturating event counters.
    always_ff @(posedge clk) begin
        if (reset) begin
            dropCount <= '0;
            missCount <= '0;
        end else begin
            if (w_drop && (dropCount != '1)) begin
                dropCount <= dropCount + StatsWidth'(1);
            end
            if (w_miss && (missCount != '1)) begin
                missCount <= missCount + StatsWidth'(1);
            end
        end
    end
`endif

    ring_fifo_mem #(
        .WordSize (WordSize),
        .AddrBits (PtrW)
    ) u_mem (
        .clk       (clk),
        .reset     (reset),
        .i_wr_en   (w_wr_accept),
        .i_wr_addr (r_wr_ptr),
        .i_wr_data (dataWrite),
        .i_rd_en   (w_rd_accept),
        .i_rd_addr (r_rd_ptr),
        .o_rd_data (dataRead)
    );

endmodule : ring_fifo

// File: tb/tb_ring_fifo.sv
// tb_ring_fifo: self-checking bench for ring_fifo (WordSize 8, Depth 8).
module tb_ring_fifo;

    localparam int DEPTH = 8;
    localparam int AFL   = 7;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        dataWriteEnable = 1'b0;
    logic [7:0]  dataWrite = 8'h00;
    logic        dataReadEnable = 1'b0;
    logic        dataReadAck;
    logic [7:0]  dataRead;
    logic [3:0]  count;
    logic        empty, full, almostFull, overflow, underflow;
`ifdef RING_FIFO_STATS_EN
    logic [15:0] dropCount, missCount;
`endif

    ring_fifo dut (
        .clk             (clk),
        .reset           (reset),
        .dataWriteEnable (dataWriteEnable),
        .dataWrite       (dataWrite),
        .dataReadEnable  (dataReadEnable),
        .dataReadAck     (dataReadAck),
        .dataRead        (dataRead),
        .count           (count),
        .empty           (empty),
        .full            (full),
        .almostFull      (almostFull),
        .overflow        (overflow),
        .underflow       (underflow)
`ifdef RING_FIFO_STATS_EN
        ,
        .dropCount       (dropCount),
        .missCount       (missCount)
`endif
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_fail   = 0;

    // Reference model state.
    logic [7:0]  model_q[$];
    logic [7:0]  exp_q[$];
    logic        m_ovf, m_unf;
    logic [7:0]  m_last;
    logic [15:0] m_drop, m_miss;

    typedef struct packed {
        logic       wen;
        logic [7:0] wd;
        logic       ren;
        logic [3:0] cnt;
        logic       emp;
        logic       ful;
        logic       af;
        logic       ovf;
        logic       unf;
    } vec_t;

    vec_t vecs[18];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic check_status();
        int sz;
        sz = model_q.size();
        check("count", 32'(count), 32'(sz));
        check("empty", 32'(empty), 32'(sz == 0));
        check("full", 32'(full), 32'(sz == DEPTH));
        check("almostFull", 32'(almostFull), 32'(sz >= AFL));
        check("overflow", 32'(overflow), 32'(m_ovf));
        check("underflow", 32'(underflow), 32'(m_unf));
`ifdef RING_FIFO_STATS_EN
        check("dropCount", 32'(dropCount), 32'(m_drop));
        check("missCount", 32'(missCount), 32'(m_miss));
`endif
    endtask

    // One clock of stimulus; model predicts, scoreboard compares after the edge.
    task automatic do_cycle(input logic wen, input logic [7:0] wd, input logic ren);
        bit rd_acc, wr_acc;
        logic [7:0] e;
        rd_acc = ren && (model_q.size() > 0);
        wr_acc = wen && ((model_q.size() < DEPTH) || rd_acc);
        if (rd_acc) exp_q.push_back(model_q.pop_front());
        if (wr_acc) model_q.push_back(wd);
        if (wen && !wr_acc) begin
            m_ovf = 1'b1;
            if (m_drop != 16'hFFFF) m_drop++;
        end
        if (ren && !rd_acc) begin
            m_unf = 1'b1;
            if (m_miss != 16'hFFFF) m_miss++;
        end
        dataWriteEnable = wen;
        dataWrite       = wd;
        dataReadEnable  = ren;
        @(posedge clk);
        #1;
        dataWriteEnable = 1'b0;
        dataReadEnable  = 1'b0;
        check("ack", 32'(dataReadAck), 32'(rd_acc));
        if (rd_acc) begin
            e = exp_q.pop_front();
            check("rdata", 32'(dataRead), 32'(e));
            m_last = e;
        end else begin
            check("rdata_hold", 32'(dataRead), 32'(m_last));
        end
        check_status();
    endtask

    task automatic do_reset(input logic wen, input logic ren);
        reset           = 1'b1;
        dataWriteEnable = wen;
        dataWrite       = 8'hEE;
        dataReadEnable  = ren;
        model_q.delete();
        exp_q.delete();
        m_ovf  = 1'b0;
        m_unf  = 1'b0;
        m_last = 8'h00;
        m_drop = 16'h0;
        m_miss = 16'h0;
        @(posedge clk);
        #1;
        reset           = 1'b0;
        dataWriteEnable = 1'b0;
        dataReadEnable  = 1'b0;
        check("rst_ack", 32'(dataReadAck), 32'h0);
        check("rst_rdata", 32'(dataRead), 32'h0);
        check_status();
    endtask

    initial begin
        // Fill, overflow, drain, underflow with hand-derived expected flags.
        for (int i = 0; i < 8; i++) begin
            vecs[i] = '{wen: 1'b1, wd: 8'(8'h11 + i), ren: 1'b0, cnt: 4'(i + 1),
                        emp: 1'b0, ful: (i == 7), af: (i >= 6), ovf: 1'b0, unf: 1'b0};
        end
        vecs[8] = '{wen: 1'b1, wd: 8'h99, ren: 1'b0, cnt: 4'd8,
                    emp: 1'b0, ful: 1'b1, af: 1'b1, ovf: 1'b1, unf: 1'b0};
        for (int i = 0; i < 8; i++) begin
            vecs[9 + i] = '{wen: 1'b0, wd: 8'h00, ren: 1'b1, cnt: 4'(7 - i),
                            emp: (i == 7), ful: 1'b0, af: (i == 0), ovf: 1'b1, unf: 1'b0};
        end
        vecs[17] = '{wen: 1'b0, wd: 8'h00, ren: 1'b1, cnt: 4'd0,
                     emp: 1'b1, ful: 1'b0, af: 1'b0, ovf: 1'b1, unf: 1'b1};

        do_reset(1'b0, 1'b0);

        for (int i = 0; i < 18; i++) begin
            do_cycle(vecs[i].wen, vecs[i].wd, vecs[i].ren);
            check("vec_count", 32'(count), 32'(vecs[i].cnt));
            check("vec_empty", 32'(empty), 32'(vecs[i].emp));
            check("vec_full", 32'(full), 32'(vecs[i].ful));
            check("vec_af", 32'(almostFull), 32'(vecs[i].af));
            check("vec_ovf", 32'(overflow), 32'(vecs[i].ovf));
            check("vec_unf", 32'(underflow), 32'(vecs[i].unf));
            if (i >= 9 && i <= 16) begin
                check("vec_rdata", 32'(dataRead), 32'(8'h11 + (i - 9)));
            end
        end
`ifdef RING_FIFO_STATS_EN
        check("stats_miss1", 32'(missCount), 32'h1);
        check("stats_drop1", 32'(dropCount), 32'h1);
`endif

        // Full with simultaneous read+write: oldest out, AA read last.
        do_reset(1'b0, 1'b0);
        for (int i = 0; i < 8; i++) do_cycle(1'b1, 8'(8'h21 + i), 1'b0);
        do_cycle(1'b1, 8'hAA, 1'b1);
        check("full_rw_data", 32'(dataRead), 32'h21);
        check("full_rw_count", 32'(count), 32'h8);
        check("full_rw_ovf", 32'(overflow), 32'h0);
        for (int i = 0; i < 8; i++) do_cycle(1'b0, 8'h00, 1'b1);
        check("aa_last", 32'(dataRead), 32'hAA);

        // Empty with simultaneous read+write: write lands, read rejected.
        do_cycle(1'b1, 8'h5C, 1'b1);
        check("empty_rw_unf", 32'(underflow), 32'h1);
        check("empty_rw_count", 32'(count), 32'h1);
        do_cycle(1'b0, 8'h00, 1'b1);
        check("empty_rw_data", 32'(dataRead), 32'h5C);

        // Interleaved traffic wrapping the pointers more than twice.
        do_reset(1'b0, 1'b0);
        for (int i = 0; i < 20; i++) do_cycle(1'b1, 8'(8'h40 + i), (i % 3) != 0);
        for (int i = 0; i < 20 && model_q.size() > 0; i++) do_cycle(1'b0, 8'h00, 1'b1);
        check("wrap_count0", 32'(count), 32'h0);
        check("wrap_last", 32'(dataRead), 32'h53);

        // Random traffic.
        for (int i = 0; i < 200; i++) begin
            do_cycle(1'($urandom_range(0, 1)), 8'($urandom), 1'($urandom_range(0, 1)));
        end

        // Reset mid-stream with a concurrent read request.
        do_reset(1'b0, 1'b0);
        for (int i = 0; i < 5; i++) do_cycle(1'b1, 8'(8'h60 + i), 1'b0);
        check("pre_rst_count", 32'(count), 32'h5);
        do_reset(1'b1, 1'b1);
        check("mid_rst_count", 32'(count), 32'h0);
        check("mid_rst_empty", 32'(empty), 32'h1);
        do_cycle(1'b0, 8'h00, 1'b1);
        check("post_rst_ack", 32'(dataReadAck), 32'h0);
        check("post_rst_unf", 32'(underflow), 32'h1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule : tb_ring_fifo
